imem_program_loader: RTL

Sequential instruction writer that accepts field-level instruction descriptors over a valid/ready stream and encodes them into RV32I machine words. Encoded words are written into consecutive instruction-memory locations. It covers exactly the opcode classes the core's control decoder recognises (R, I-ALU, LOAD, STORE, BRANCH, JAL) and is used for bench program loading and boot-time patching of instruction memory.

---
 rtl/imem_program_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Encodes RV32I field descriptors (R, I-ALU, LOAD, STORE, BRANCH, JAL) into machine
// words and writes them to consecutive instruction-memory words through one write register.
module imem_program_loader #(
  parameter int DEPTH = 1024,
  parameter int CW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] count,
  output logic [1:0]    dbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loaderState;

  loaderState state, stateNext;
  logic [CW-1:0] countNext;
  logic          errNext;
  logic          weNext;
  logic [31:0]   addrNext;
  logic [31:0]   wdataNext;
  logic [31:0]   wordEnc;
  logic          beatOk;
  logic          accept;
  logic          fits12, fits13, fits21;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready
  // comes from registered state and count only, and in_* hold while stalled.
  assign in_ready = (state == LOAD) && (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == LOAD) || (state == FLUSH);
  assign done     = (state == DONE);
  assign dbgState = state;

  // Signed fit: every bit above the field's sign bit must equal that sign bit.
  assign fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    wordEnc = '0;
    beatOk  = 1'b0;
    case (in_kind)
      3'd0: begin
        wordEnc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        beatOk  = 1'b1;
      end
      3'd1: begin
        wordEnc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        beatOk  = fits12;
      end
      3'd2: begin
        wordEnc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        beatOk  = fits12;
      end
      3'd3: begin
        wordEnc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        beatOk  = fits12;
      end
      3'd4: begin
        wordEnc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], 7'b1100011};
        beatOk  = fits13 && !in_imm[0];
      end
      3'd5: begin
        wordEnc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        beatOk  = fits21 && !in_imm[0];
      end
      default: begin
        wordEnc = '0;
        beatOk  = 1'b0;
      end
    endcase
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    errNext   = err;
    weNext    = 1'b0;
    addrNext  = mem_addr;
    wdataNext = mem_wdata;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext = LOAD;
          countNext = '0;
          errNext   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (beatOk) begin
            weNext    = 1'b1;
            addrNext  = {{(30-CW){1'b0}}, count, 2'b00};
            wdataNext = wordEnc;
            countNext = count + CW'(1);
            // The word that fills memory ends the load; without in_last it is a truncation.
            if (in_last || count == CW'(DEPTH - 1)) stateNext = FLUSH;
            if (!in_last && count == CW'(DEPTH - 1)) errNext = 1'b1;
          end else begin
            errNext = 1'b1;
            if (in_last) stateNext = FLUSH;
          end
        end
      end
      FLUSH: stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      err       <= errNext;
      mem_we    <= weNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
    end
  end

endmodule
